// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for mem_port_arbiter (FSM states, owner tag, latched request).
package mem_arb_pkg;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic                  we;
        owner_t                owner;
    } mem_req_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request-response ports plus the shared memory port.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;
    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_we;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    modport slave (
        input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_wdata, d_req_we, mem_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_rdata,
               mem_addr, mem_wdata, mem_we, busy
    );
    modport master (
        output i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_wdata, d_req_we, mem_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_rdata,
               mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks the requester that sees ready while the FSM is idle.
// MEM_ARB_RR_EN selects round-robin against the last owner; otherwise data beats fetch.
module mem_arb_grant import mem_arb_pkg::*; (
    input  logic   i_valid_i,
    input  logic   d_valid_i,
    input  logic   idle_i,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_owner_i,
`endif
    output logic   i_ready_o,
    output logic   d_ready_o
);
    logic d_win;
`ifdef MEM_ARB_RR_EN
    assign d_win = d_valid_i && (!i_valid_i || last_owner_i == OWN_I);
`else
    assign d_win = d_valid_i;
`endif
    assign d_ready_o = idle_i && d_win;
    assign i_ready_o = idle_i && i_valid_i && !d_win;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store requests onto one single-port memory.
// Define MEM_ARB_RR_EN for round-robin grant; default is fixed data-over-fetch priority.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;

    if (MEM_LATENCY < 1) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
    end
    if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W) begin : g_width_chk
        $error("mem_port_arbiter: ADDR_W/DATA_W must match mem_arb_pkg widths");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              idle, i_ready, d_ready, last_cyc;
`ifdef MEM_ARB_RR_EN
    owner_t            last_q, last_d;
`endif

    // Ready is held low while reset is asserted, even though the FSM sits in IDLE.
    assign idle     = rst_n && state_q == IDLE;
    assign last_cyc = cnt_q == CNT_W'(MEM_LATENCY - 1);

    mem_arb_grant u_grant (
        .i_valid_i    (bus.i_req_valid),
        .d_valid_i    (bus.d_req_valid),
        .idle_i       (idle),
`ifdef MEM_ARB_RR_EN
        .last_owner_i (last_q),
`endif
        .i_ready_o    (i_ready),
        .d_ready_o    (d_ready)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
`endif
        if (state_q == IDLE && (i_ready || d_ready)) begin
            state_d = ACCESS;
            cnt_d   = '0;
            req_d   = d_ready ? mem_req_t'{bus.d_req_addr, bus.d_req_wdata, bus.d_req_we, OWN_D}
                              : mem_req_t'{bus.i_req_addr, ARB_DATA_W'(0), 1'b0, OWN_I};
`ifdef MEM_ARB_RR_EN
            last_d  = d_ready ? OWN_D : OWN_I;
`endif
        end else if (state_q == ACCESS) begin
            cnt_d   = last_cyc ? '0 : cnt_q + CNT_W'(1);
            state_d = last_cyc ? RESP : ACCESS;
            if (last_cyc && req_q.owner == OWN_I) i_rdata_d = bus.mem_rdata;
            if (last_cyc && req_q.owner == OWN_D) d_rdata_d = req_q.we ? '0 : bus.mem_rdata;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q    <= OWN_I;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.i_req_ready = i_ready;
    assign bus.d_req_ready = d_ready;
    assign bus.i_rsp_valid = state_q == RESP && req_q.owner == OWN_I;
    assign bus.d_rsp_valid = state_q == RESP && req_q.owner == OWN_D;
    assign bus.i_rsp_data  = i_rdata_q;
    assign bus.d_rsp_rdata = d_rdata_q;
    assign bus.mem_addr    = req_q.addr;
    assign bus.mem_wdata   = req_q.wdata;
    // Strobe only on the first access cycle so multi-cycle memories see a single write.
    assign bus.mem_we      = state_q == ACCESS && cnt_q == '0 && req_q.we;
    assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench; u0 runs MEM_LATENCY=1, u1 runs MEM_LATENCY=3 back-to-back loads.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc_n = 0;
    int   checks = 0;
    int   failures = 0;
    int   we_cnt, d_cnt, d_at, i_cnt, i_at;
    logic [31:0] d_dat, i_dat;
    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.MEM_LATENCY(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mem_port_arbiter #(.MEM_LATENCY(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    assign bus0.mem_rdata = mem0[bus0.mem_addr[5:2]];
    assign bus1.mem_rdata = mem1[bus1.mem_addr[5:2]];

    always @(posedge clk)
        if (!rst_n) begin
            foreach (mem0[k]) begin
                mem0[k] <= '0;
                mem1[k] <= 32'hA500_0000 | 32'(k);
            end
            mem0[0] <= 32'h0000_0013;
        end else if (bus0.mem_we) begin
            mem0[bus0.mem_addr[5:2]] <= bus0.mem_wdata;
        end

    task automatic clr0();
        we_cnt = 0; d_cnt = 0; i_cnt = 0; d_at = -1; i_at = -1; d_dat = 'x; i_dat = 'x;
    endtask

    task automatic run0(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            if (bus0.mem_we) we_cnt++;
            if (bus0.d_rsp_valid) begin d_cnt++; d_at = cyc_n; d_dat = bus0.d_rsp_rdata; end
            if (bus0.i_rsp_valid) begin i_cnt++; i_at = cyc_n; i_dat = bus0.i_rsp_data; end
            @(posedge clk); #1;
        end
    endtask

    task automatic req0(input bit is_d, input logic [31:0] a, input logic [31:0] wd, input logic we,
                        output int acc, output bit ok);
        if (is_d) begin
            bus0.d_req_valid = 1'b1; bus0.d_req_addr = a; bus0.d_req_wdata = wd; bus0.d_req_we = we;
        end else begin
            bus0.i_req_valid = 1'b1; bus0.i_req_addr = a;
        end
        #1;
        ok = 1'b0; acc = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (is_d ? bus0.d_req_ready : bus0.i_req_ready) begin ok = 1'b1; acc = cyc_n; end
            else begin @(posedge clk); #2; end
        end
        @(posedge clk); #1;
        if (is_d) bus0.d_req_valid = 1'b0; else bus0.i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus0.i_req_valid = 1'b1; bus0.d_req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus0.i_req_ready, bus0.d_req_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {bus0.i_req_ready, bus0.d_req_ready}); end
        checks++; if ({bus0.i_rsp_valid, bus0.d_rsp_valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", {bus0.i_rsp_valid, bus0.d_rsp_valid}); end
        checks++; if (bus0.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus0.mem_we); end
        checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
        checks++; if ({bus0.mem_addr, bus0.i_rsp_data, bus0.d_rsp_rdata} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus0.mem_addr, bus0.i_rsp_data, bus0.d_rsp_rdata}); end
        bus0.i_req_valid = 1'b0; bus0.d_req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int acc; bit ok;
        clr0();
        req0(1'b1, 32'h4, 32'hCAFE_BABE, 1'b1, acc, ok);
        run0(4);
        checks++; if (!ok) begin failures++; $display("FAIL store_ready got=0 exp=1"); end
        checks++; if (d_cnt !== 1 || d_at !== acc + 2) begin failures++; $display("FAIL store_rsp_timing got cnt=%0d at=%0d exp cnt=1 at=%0d", d_cnt, d_at, acc + 2); end
        checks++; if (d_dat !== 32'h0) begin failures++; $display("FAIL store_rsp_rdata got=%h exp=00000000", d_dat); end
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL store_mem_we got=%0d exp=1", we_cnt); end
        checks++; if (i_cnt !== 0) begin failures++; $display("FAIL store_i_rsp got=%0d exp=0", i_cnt); end
        clr0();
        req0(1'b1, 32'h4, 32'h0, 1'b0, acc, ok);
        run0(4);
        checks++; if (!ok || d_cnt !== 1 || d_at !== acc + 2) begin failures++; $display("FAIL load_rsp_timing got ok=%0d cnt=%0d at=%0d exp at=%0d", ok, d_cnt, d_at, acc + 2); end
        checks++; if (d_dat !== 32'hCAFE_BABE) begin failures++; $display("FAIL load_rdata got=%h exp=cafebabe", d_dat); end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL load_mem_we got=%0d exp=0", we_cnt); end
    endtask

    task automatic test_fetch();
        int acc; bit ok;
        clr0();
        req0(1'b0, 32'h0, 32'h0, 1'b0, acc, ok);
        run0(4);
        checks++; if (!ok || i_cnt !== 1 || i_at !== acc + 2) begin failures++; $display("FAIL fetch_rsp_timing got ok=%0d cnt=%0d at=%0d exp at=%0d", ok, i_cnt, i_at, acc + 2); end
        checks++; if (i_dat !== 32'h0000_0013) begin failures++; $display("FAIL fetch_data got=%h exp=00000013", i_dat); end
        checks++; if (d_cnt !== 0) begin failures++; $display("FAIL fetch_d_rsp got=%0d exp=0", d_cnt); end
        checks++; if (bus0.d_rsp_rdata !== 32'hCAFE_BABE) begin failures++; $display("FAIL fetch_d_hold got=%h exp=cafebabe", bus0.d_rsp_rdata); end
    endtask

    task automatic test_store_ack();
        int acc; bit ok;
        clr0();
        req0(1'b1, 32'h8, 32'h1234_5678, 1'b1, acc, ok);
        run0(4);
        checks++; if (!ok || d_cnt !== 1 || d_at !== acc + 2 || d_dat !== 32'h0) begin failures++; $display("FAIL store2_ack got cnt=%0d at=%0d rdata=%h exp cnt=1 at=%0d rdata=0", d_cnt, d_at, d_dat, acc + 2); end
        checks++; if (bus0.i_rsp_data !== 32'h0000_0013) begin failures++; $display("FAIL store2_i_hold got=%h exp=00000013", bus0.i_rsp_data); end
        checks++; if (mem0[2] !== 32'h1234_5678) begin failures++; $display("FAIL store2_mem got=%h exp=12345678", mem0[2]); end
    endtask

    task automatic test_arbitration();
        int acc, acc2; bit d_first;
        d_first = !RR;
        clr0();
        bus0.i_req_valid = 1'b1; bus0.i_req_addr = 32'h0;
        bus0.d_req_valid = 1'b1; bus0.d_req_addr = 32'h4; bus0.d_req_we = 1'b0; bus0.d_req_wdata = '0;
        #1;
        checks++; if ({bus0.d_req_ready, bus0.i_req_ready} !== (d_first ? 2'b10 : 2'b01)) begin failures++; $display("FAIL arb_first_grant got d,i=%b exp=%b", {bus0.d_req_ready, bus0.i_req_ready}, d_first ? 2'b10 : 2'b01); end
        acc = cyc_n;
        @(posedge clk); #1;
        if (d_first) bus0.d_req_valid = 1'b0; else bus0.i_req_valid = 1'b0;
        run0(2);
        #1;
        checks++; if ({bus0.d_req_ready, bus0.i_req_ready} !== (d_first ? 2'b01 : 2'b10)) begin failures++; $display("FAIL arb_second_grant got d,i=%b exp=%b", {bus0.d_req_ready, bus0.i_req_ready}, d_first ? 2'b01 : 2'b10); end
        acc2 = cyc_n;
        @(posedge clk); #1;
        bus0.d_req_valid = 1'b0; bus0.i_req_valid = 1'b0;
        run0(4);
        checks++; if (acc2 !== acc + 3) begin failures++; $display("FAIL arb_second_accept got=%0d exp=%0d", acc2, acc + 3); end
        checks++; if (d_cnt !== 1 || d_at !== (d_first ? acc + 2 : acc + 5)) begin failures++; $display("FAIL arb_d_rsp got cnt=%0d at=%0d exp cnt=1 at=%0d", d_cnt, d_at, d_first ? acc + 2 : acc + 5); end
        checks++; if (i_cnt !== 1 || i_at !== (d_first ? acc + 5 : acc + 2)) begin failures++; $display("FAIL arb_i_rsp got cnt=%0d at=%0d exp cnt=1 at=%0d", i_cnt, i_at, d_first ? acc + 5 : acc + 2); end
        checks++; if (d_dat !== 32'hCAFE_BABE || i_dat !== 32'h0000_0013) begin failures++; $display("FAIL arb_data got d=%h i=%h exp d=cafebabe i=00000013", d_dat, i_dat); end
    endtask

    task automatic test_reset_mid_access();
        int acc; bit ok;
        clr0();
        req0(1'b1, 32'hC, 32'hDEAD_BEEF, 1'b1, acc, ok);
        #1;
        checks++; if (!ok || {bus0.busy, bus0.mem_we} !== 2'b11) begin failures++; $display("FAIL midrst_in_access got ok=%0d busy,we=%b exp 1,11", ok, {bus0.busy, bus0.mem_we}); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus0.busy, bus0.mem_we, bus0.d_rsp_valid} !== 3'b000) begin failures++; $display("FAIL midrst_outputs got busy,we,rsp=%b exp=000", {bus0.busy, bus0.mem_we, bus0.d_rsp_valid}); end
        #1 rst_n = 1'b1;
        run0(4);
        checks++; if (d_cnt !== 0 || we_cnt !== 0) begin failures++; $display("FAIL midrst_dropped got rsp=%0d we=%0d exp 0,0", d_cnt, we_cnt); end
        checks++; if (mem0[3] !== 32'h0) begin failures++; $display("FAIL midrst_mem got=%h exp=00000000", mem0[3]); end
        clr0();
        req0(1'b1, 32'h4, 32'h0, 1'b0, acc, ok);
        run0(4);
        checks++; if (!ok || d_cnt !== 1 || d_at !== acc + 2 || d_dat !== 32'hCAFE_BABE) begin failures++; $display("FAIL midrst_load got cnt=%0d at=%0d data=%h exp cnt=1 at=%0d data=cafebabe", d_cnt, d_at, d_dat, acc + 2); end
    endtask

    task automatic test_back_to_back();
        int acc [8];
        int at [8];
        logic [31:0] dat [8];
        int na, nr; bit hs;
        na = 0; nr = 0;
        foreach (acc[k]) begin acc[k] = 0; at[k] = 0; dat[k] = 'x; end
        bus1.d_req_valid = 1'b1; bus1.d_req_addr = 32'h0; bus1.d_req_we = 1'b0;
        for (int t = 0; t < 80 && nr < 8; t++) begin
            #1;
            hs = bus1.d_req_ready;
            if (hs && na < 8) begin acc[na] = cyc_n; na++; end
            if (bus1.d_rsp_valid && nr < 8) begin at[nr] = cyc_n; dat[nr] = bus1.d_rsp_rdata; nr++; end
            @(posedge clk); #1;
            if (hs) begin bus1.d_req_addr = 32'(na * 4); bus1.d_req_valid = na < 8; end
        end
        bus1.d_req_valid = 1'b0;
        checks++; if (na !== 8 || nr !== 8) begin failures++; $display("FAIL b2b_counts got acc=%0d rsp=%0d exp 8,8", na, nr); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (at[k] - acc[k] !== 4) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=4", k, at[k] - acc[k]); end
            checks++; if (dat[k] !== (32'hA500_0000 | 32'(k))) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, dat[k], 32'hA500_0000 | 32'(k)); end
            if (k > 0) begin
                checks++; if (acc[k] - acc[k-1] !== 5) begin failures++; $display("FAIL b2b_period[%0d] got=%0d exp=5", k, acc[k] - acc[k-1]); end
            end
        end
    endtask

    initial begin
        bus0.i_req_valid = 1'b0; bus0.i_req_addr = '0;
        bus0.d_req_valid = 1'b0; bus0.d_req_addr = '0; bus0.d_req_wdata = '0; bus0.d_req_we = 1'b0;
        bus1.i_req_valid = 1'b0; bus1.i_req_addr = '0;
        bus1.d_req_valid = 1'b0; bus1.d_req_addr = '0; bus1.d_req_wdata = '0; bus1.d_req_we = 1'b0;
        test_reset();
        test_store_load();
        test_fetch();
        test_store_ack();
        test_arbitration();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
